// File: rtl/tag_free_pool.sv
// Circular FIFO pool of free instruction tags: dispatch pops from the head, commit pushes to the tail.
// Optional macro TAG_POOL_DUP_CHECK_EN adds a free_map that rejects duplicate frees.
module tag_free_pool #(
   parameter int unsigned WIDTH        = 5,
   parameter int unsigned DEPTH        = 32,
   parameter int unsigned ADDRESSWIDTH = 6
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    alloc_req,
   output logic [WIDTH-1:0]        alloc_tag,
   output logic                    alloc_valid,
   input  logic                    free_req,
   input  logic [WIDTH-1:0]        free_tag,
   output logic [ADDRESSWIDTH-1:0] count,
   output logic                    empty,
   output logic                    full,
   output logic                    overflow_err,
   output logic                    dup_err
);

   logic [WIDTH-1:0]        entry [DEPTH];
   logic [WIDTH-1:0]        rd_ptr;
   logic [WIDTH-1:0]        wr_ptr;
   logic [ADDRESSWIDTH-1:0] count_nxt;
   logic                    pop;
   logic                    push;
   logic                    dup_hit;
   logic                    ovf_hit;

   // Show-ahead head of the pool; no bypass of a same-cycle free.
   assign alloc_tag   = entry[rd_ptr];
   assign alloc_valid = !empty;
   assign pop         = alloc_req && !empty;

`ifdef TAG_POOL_DUP_CHECK_EN
   logic [DEPTH-1:0] free_map;

   // A free of the tag leaving this same cycle is legal even though its bit is still set.
   assign dup_hit = free_req && free_map[free_tag] && !(pop && (free_tag == alloc_tag));
   assign push    = free_req && !dup_hit && (!full || pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         free_map <= '1;
      end else begin
         if (pop)  free_map[alloc_tag] <= 1'b0;
         if (push) free_map[free_tag]  <= 1'b1;
      end
   end
`else
   assign dup_hit = 1'b0;
   assign push    = free_req && (!full || pop);
`endif

   // Duplicate rejection takes priority, so a dropped duplicate never reports overflow.
   assign ovf_hit = free_req && !dup_hit && full && !pop;

   always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + ADDRESSWIDTH'(1);
      else if (pop && !push) count_nxt = count - ADDRESSWIDTH'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entry[i] <= WIDTH'(i);
         end
      end else if (push) begin
         entry[wr_ptr] <= free_tag;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= ADDRESSWIDTH'(DEPTH);
         empty        <= 1'b0;
         full         <= 1'b1;
         overflow_err <= 1'b0;
         dup_err      <= 1'b0;
      end else begin
         if (pop)  rd_ptr <= rd_ptr + WIDTH'(1);
         if (push) wr_ptr <= wr_ptr + WIDTH'(1);
         count        <= count_nxt;
         empty        <= (count_nxt == '0);
         full         <= (count_nxt == ADDRESSWIDTH'(DEPTH));
         overflow_err <= ovf_hit;
         dup_err      <= dup_hit;
      end
   end

endmodule

// File: doc/tag_free_pool.md
# tag_free_pool

- Circular pool of free 5-bit instruction tags.
- Dispatch takes a tag from it when an instruction enters the order queue; commit returns the tag when that instruction retires.
- It is the producing end of the tag stream that the order queue carries.
- After reset it holds every tag 0..DEPTH-1; allocation pops in FIFO order, and freed tags are appended at the tail.

## Interface

- WIDTH, 5, tag width in bits
- DEPTH, 32, number of tags in the pool (must equal 2^WIDTH)
- ADDRESSWIDTH, 6, width of the occupancy count (log2(DEPTH)+1)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears/initialises all state
- alloc_req  in  1  dispatch takes the tag shown on alloc_tag this cycle
- alloc_tag  out  WIDTH  tag at the head of the pool (show-ahead)
- alloc_valid  out  1  pool non-empty; alloc_tag is meaningful
- free_req  in  1  commit returns free_tag this cycle
- free_tag  in  WIDTH  tag being returned
- count  out  ADDRESSWIDTH  number of free tags held
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow_err  out  1  one-cycle pulse: a free was rejected because the pool was full with no same-cycle alloc
- dup_err  out  1  one-cycle pulse: a free was rejected as a duplicate (configuration-dependent)

## Operation

- Storage is DEPTH x WIDTH registers, plus a read pointer and a write pointer (both WIDTH bits, natural wrap at DEPTH) and a count register.
- Reset state:
  - entry[i] = i
  - rd_ptr = 0, wr_ptr = 0
  - count = DEPTH
  - full = 1, empty = 0, alloc_valid = 1, alloc_tag = 0
  - overflow_err = 0, dup_err = 0
- alloc_tag = entry[rd_ptr], combinational from registered state. alloc_valid = !empty.
- Pop occurs when alloc_req && !empty: rd_ptr += 1.
  - alloc_req while empty is ignored; no state change and no error.
- Push occurs when free_req is accepted: entry[wr_ptr] = free_tag and wr_ptr += 1.
  - Accepted when count < DEPTH, or when a pop occurs in the same cycle.
- Full with free_req and no pop: push is dropped and overflow_err pulses the next cycle.
- count update per cycle:
  - +1 on push only
  - -1 on pop only
  - unchanged on both or neither
- Empty with simultaneous alloc_req and free_req: the pop is refused (alloc_valid was 0), the push is accepted, and count becomes 1. There is no bypass of free_tag to alloc_tag in the same cycle.
- Wrap-around: the pointers wrap modulo DEPTH with no special handling. Ordering is strict FIFO across the wrap.
- Reset asserted mid-operation reinitialises everything immediately (asynchronously). Any pending alloc/free in that cycle is lost.

## Timing

- Allocation has zero latency: the tag on alloc_tag in the cycle alloc_req is high is the tag taken.
- A freed tag becomes visible on alloc_tag no earlier than the cycle after the push. It reaches the head only after all older entries.
- count, empty and full are registered and reflect the previous edge's operations. They update at the same edge as the pointers.
- overflow_err and dup_err are registered, high for exactly one cycle after the offending edge.
- Throughput is one alloc and one free per cycle, sustained.

## Configuration

- Macro: TAG_POOL_DUP_CHECK_EN.
- Defined:
  - Maintain a DEPTH-bit free_map. Reset sets it to all ones.
  - A pop clears bit[alloc_tag]; an accepted push sets bit[free_tag].
  - A free whose bit is already set, and which is not the tag being popped in the same cycle, is dropped: no push, no count change. dup_err pulses the next cycle.
  - The duplicate check takes priority over the overflow check. A rejected duplicate never raises overflow_err.
  - A free of the tag popped in the same cycle is accepted, and its bit ends set.
- Not defined:
  - No free_map is built; dup_err is tied to 0.
  - Duplicate frees are accepted like any other free, subject only to the overflow rule.

## Test plan

- Reset, then alloc_req held 32 cycles -> alloc_tag reads 0,1,...,31 in order; after the 32nd pop empty=1, alloc_valid=0, count=0; a 33rd alloc_req changes nothing.
- From empty, free tags 7,3,20 on consecutive cycles -> count goes 1,2,3; subsequent allocs return 7,3,20; free_tag 9 with alloc_req high while empty -> count=1, no pop.
- Steady state (count=10): alloc_req and free_req (tag 5) together for 40 cycles -> count stays 10, pointers wrap, returned tags come back in free order.
- Full pool, free_req with tag 4 and no alloc -> count stays 32, overflow_err high one cycle; repeat with alloc_req high -> accepted, count stays 32, no error.
- With TAG_POOL_DUP_CHECK_EN defined: reset, alloc tags 0,1, free 1, free 1 again -> second free dropped, dup_err one-cycle pulse, count=31; same sequence without the macro -> count=32 after the second free, dup_err=0.
- Assert reset mid-stream with count=12 and wr_ptr=rd_ptr+12 -> next cycle count=32, full=1, alloc_tag=0, errors low.
